id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the register file in the ID stage.
- Captures the two register read values, the immediate, the register addresses and the decoded control bits.
- Presents them to EX one cycle later.
- Detects load-use hazards, inserts bubbles and back-pressures IF/ID and PC through id_stall.
- Honours EX back-pressure (hold) and branch flush.

Parameters:
- DATA_W, 8, width of register data and immediate
- REG_ADDR_W, 3, register address width (8 architectural registers)
- ALUOP_W, 2, ALU operation code width
- CNT_W, 8, width of the saturating bubble counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- id_valid  in  1  ID holds a real instruction this cycle
- id_readdata1  in  DATA_W  rs1 value from the register file
- id_readdata2  in  DATA_W  rs2 value from the register file
- id_imm  in  DATA_W  decoded immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  each  source/destination addresses
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1 each  decoded control
- id_aluop  in  ALUOP_W  ALU op class
- ex_ready  in  1  EX can accept a new instruction; 0 = hold
- ex_flush  in  1  branch taken in EX; squash the ID/EX contents
- ex_valid  out  1  EX slot holds a real instruction
- ex_readdata1, ex_readdata2, ex_imm  out  DATA_W  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered copies
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1  registered control
- ex_aluop  out  ALUOP_W  registered ALU op
- id_stall  out  1  freeze PC and IF/ID this cycle
- bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (reset==0, asynchronous): every registered output goes to 0, including ex_valid and bubble_count. id_stall then evaluates to 0. Reset may assert mid-operation and must take effect immediately, without waiting for a clock edge.
- hazard (combinational) = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - Register 0 never creates a hazard.
- hold (combinational) = ex_valid & ~ex_ready.
- id_stall (combinational) = (hazard | hold) & ~ex_flush.
- Per rising edge, the first matching rule applies:
  1. ex_flush=1: bubble. ex_valid=0; all control outputs, data, immediate and address outputs = 0. bubble_count is unchanged.
  2. hold: every output keeps its value. bubble_count is unchanged, even if hazard=1.
  3. hazard: bubble, as in rule 1. bubble_count increments by 1 and saturates at 2^CNT_W-1.
  4. Otherwise, load: ex_valid<=id_valid and all ex_* fields take the id_* values.
     - When id_valid=0, control outputs are forced to 0; data fields still load.
- Latency: 1 cycle from ID to EX.
- A load-use pair costs exactly one bubble cycle. The hazard self-clears because the bubble leaves ex_memread=0.
- Implicit two-state slot, EMPTY (ex_valid=0) / FULL (ex_valid=1):
  - EMPTY -> FULL on load with id_valid=1.
  - FULL -> EMPTY on flush, bubble, or load with id_valid=0.
  - FULL stays FULL on hold.
- Bubbles guarantee that ex_regwrite and ex_memwrite are 0 whenever ex_valid=0.
- No forwarding is performed here. Forwarding lives in EX.

Decomposition:
- Package id_ex_pkg:
  - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
  - ctrl_t, a packed struct holding the seven control fields.
  - The bubble constant CTRL_NOP (all zero).
- One combinational sub-module, load_use_detect. It takes id_valid, id_rs1, id_rs2, ex_valid, ex_memread and ex_rd, and outputs hazard.
- The register, hold/flush priority and counter stay in the top module.

Test Plan:
1. Reset: drive reset=0 mid-cycle with ex_valid=1 -> all outputs are 0 immediately, without a clock edge; id_stall=0; bubble_count=0.
2. Pass-through: id_valid=1, readdata1=8'h3C, readdata2=8'hA5, rd=3, regwrite=1, ex_ready=1 -> on the next edge ex_valid=1, ex_readdata1=3C, ex_readdata2=A5, ex_rd=3, ex_regwrite=1; id_stall=0.
3. Load-use: a load with rd=2 is in EX (ex_memread=1); ID has rs2=2 -> id_stall=1 for exactly 1 cycle; the next EX slot is a bubble (ex_valid=0, all control 0); bubble_count=1; the dependent instruction enters EX on the following edge. Repeat with rd=0 -> no stall.
4. Hold priority: ex_ready=0, ex_valid=1, hazard present -> outputs frozen for 3 cycles; id_stall=1; bubble_count unchanged; ex_ready=1 then resolves the hazard with one bubble.
5. Flush priority: ex_flush=1 together with hazard and hold -> next edge gives ex_valid=0 and all fields 0; id_stall=0; bubble_count unchanged.
6. Saturation: force 260 load-use bubbles -> bubble_count reads 255 and stays at 255.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package id_ex_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_REG_ADDR_W = 3;
    localparam int DEF_ALUOP_W    = 2;
    localparam int DEF_CNT_W      = 8;

    localparam logic [DEF_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [DEF_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [DEF_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // Decoded control bundle carried from ID into EX.
    typedef struct packed {
        logic                   regwrite;
        logic                   memread;
        logic                   memwrite;
        logic                   memtoreg;
        logic                   alusrc;
        logic                   branch;
        logic [DEF_ALUOP_W-1:0] aluop;
    } ctrl_t;

    // A bubble carries no side effects: nothing written, nothing read.
    localparam ctrl_t CTRL_NOP = '0;

    // Control of a non-instruction slot must never reach EX.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_reg_if
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W,
    parameter int CNT_W      = DEF_CNT_W
) ();
    logic                  id_valid;
    logic [DATA_W-1:0]     id_readdata1;
    logic [DATA_W-1:0]     id_readdata2;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_memwrite;
    logic                  id_memtoreg;
    logic                  id_alusrc;
    logic                  id_branch;
    logic [ALUOP_W-1:0]    id_aluop;
    logic                  ex_ready;
    logic                  ex_flush;

    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_readdata1;
    logic [DATA_W-1:0]     ex_readdata2;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  ex_memwrite;
    logic                  ex_memtoreg;
    logic                  ex_alusrc;
    logic                  ex_branch;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic                  id_stall;
    logic [CNT_W-1:0]      bubble_count;

    // Pipeline-side driver (ID stage, EX feedback).
    modport master (
        output id_valid, id_readdata1, id_readdata2, id_imm, id_rs1, id_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
               id_branch, id_aluop, ex_ready, ex_flush,
        input  ex_valid, ex_readdata1, ex_readdata2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
               ex_branch, ex_aluop, id_stall, bubble_count
    );

    // The stage register itself.
    modport slave (
        input  id_valid, id_readdata1, id_readdata2, id_imm, id_rs1, id_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
               id_branch, id_aluop, ex_ready, ex_flush,
        output ex_valid, ex_readdata1, ex_readdata2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
               ex_branch, ex_aluop, id_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard: the load now in EX writes a register ID is about to read.
module load_use_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  hazard_o
);
    // Register 0 is hard-wired, so a load targeting it never blocks anyone.
    always_comb begin
        hazard_o = id_valid_i & ex_valid_i & ex_memread_i & (ex_rd_i != '0)
                 & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    end
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    id_ex_stage_reg_if.slave  bus
);
    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     rd1_q, rd1_d;
    logic [DATA_W-1:0]     rd2_q, rd2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    ctrl_t id_ctrl;
    logic  hazard;
    logic  hold;

    assign id_ctrl = '{regwrite: bus.id_regwrite, memread: bus.id_memread,
                       memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                       alusrc: bus.id_alusrc, branch: bus.id_branch,
                       aluop: bus.id_aluop};

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
        .id_valid_i   (bus.id_valid),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_rd_i      (rd_q),
        .hazard_o     (hazard)
    );

    assign hold = valid_q & ~bus.ex_ready;

    // Next slot contents: flush beats hold beats hazard beats a normal load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (bus.ex_flush || (!hold && hazard)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            // Only hazard bubbles are counted, and the count sticks at all-ones.
            if (!bus.ex_flush && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!hold) begin
            valid_d = bus.id_valid;
            ctrl_d  = gate_ctrl(id_ctrl, bus.id_valid);
            rd1_d   = bus.id_readdata1;
            rd2_d   = bus.id_readdata2;
            imm_d   = bus.id_imm;
            rs1_d   = bus.id_rs1;
            rs2_d   = bus.id_rs2;
            rd_d    = bus.id_rd;
        end
    end

    // Slot state register; reset clears it immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_readdata1 = rd1_q;
    assign bus.ex_readdata2 = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_regwrite  = ctrl_q.regwrite;
    assign bus.ex_memread   = ctrl_q.memread;
    assign bus.ex_memwrite  = ctrl_q.memwrite;
    assign bus.ex_memtoreg  = ctrl_q.memtoreg;
    assign bus.ex_alusrc    = ctrl_q.alusrc;
    assign bus.ex_branch    = ctrl_q.branch;
    assign bus.ex_aluop     = ctrl_q.aluop;
    assign bus.bubble_count = cnt_q;
    // A flush already empties the slot, so there is nothing left to stall for.
    assign bus.id_stall     = (hazard | hold) & ~bus.ex_flush;
endmodule
